// File: rtl/pupil_locator.sv
// pupil_locator: end-of-pipeline consumer of the masked RGB pixel stream.
// Each valid pixel is reduced to gray = (R + 2G + B) >> 2 and called dark when
// gray < THRESH. Over one frame (iFVAL high) the count and bounding box of the
// dark pixels are accumulated; after the frame ends the box, its center, the
// count and a found flag are published together with a one-cycle strobe.
//
// Ports:
//   iCLK, iRST              pixel clock, asynchronous active-low reset
//   iFVAL, iDVAL            frame valid, pixel valid
//   iH_Cont, iV_Cont        pixel column / row (13 bits, full range honored)
//   iRed, iGreen, iBlue     10-bit pixel color (masked pixels arrive as 0)
//   oX_MIN..oY_MAX          dark bounding box of the last completed frame
//   oX_C, oY_C              box center
//   oCOUNT                  dark-pixel count of the last completed frame
//   oFOUND                  oCOUNT >= MIN_COUNT
//   oRES_VAL                one-cycle strobe when the result outputs update
//   oBUSY                   high while a frame is accumulated or flushed
module pupil_locator #(
  parameter logic [9:0]  THRESH    = 10'd128,
  parameter logic [23:0] MIN_COUNT = 24'd64
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iFVAL,
  input  logic        iDVAL,
  input  logic [12:0] iH_Cont,
  input  logic [12:0] iV_Cont,
  input  logic [9:0]  iRed,
  input  logic [9:0]  iGreen,
  input  logic [9:0]  iBlue,
  output logic [12:0] oX_MIN,
  output logic [12:0] oX_MAX,
  output logic [12:0] oY_MIN,
  output logic [12:0] oY_MAX,
  output logic [12:0] oX_C,
  output logic [12:0] oY_C,
  output logic [23:0] oCOUNT,
  output logic        oFOUND,
  output logic        oRES_VAL,
  output logic        oBUSY
);

  localparam int unsigned CW = 13;   // coordinate width
  localparam int unsigned SW = 12;   // R + 2G + B sum width
  localparam int unsigned NW = 24;   // dark-pixel counter width

  localparam logic [CW-1:0] COORD_MAX = '1;
  localparam logic [NW-1:0] CNT_MAX   = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state;

  // ---------------------------------------------------------------------------
  // Frame-valid edge detection. The delay register resets high so that a
  // frame already running when reset releases is not mistaken for a new one.
  // ---------------------------------------------------------------------------
  logic fvalD;
  logic fvalRise;
  logic fvalFall;

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) fvalD <= 1'b1;
    else       fvalD <= iFVAL;
  end

  assign fvalRise = iFVAL & ~fvalD;
  assign fvalFall = ~iFVAL & fvalD;

  // ---------------------------------------------------------------------------
  // Stage 1: dark classification. gray < THRESH with gray = sum >> 2 is the
  // same as sum < 4*THRESH, which avoids discarding the two fraction bits.
  // ---------------------------------------------------------------------------
  logic [SW-1:0] graySum;
  logic          pixDark;

  assign graySum = SW'(iRed) + SW'({iGreen, 1'b0}) + SW'(iBlue);
  assign pixDark = iDVAL & iFVAL & (graySum < {THRESH, 2'b00});

  logic          darkS1;
  logic [CW-1:0] hS1;
  logic [CW-1:0] vS1;

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      darkS1 <= 1'b0;
      hS1    <= '0;
      vS1    <= '0;
    end else begin
      darkS1 <= pixDark;
      hS1    <= iH_Cont;
      vS1    <= iV_Cont;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2 accumulator update values for the pixel held in stage 1.
  // ---------------------------------------------------------------------------
  logic [NW-1:0] cnt;
  logic [CW-1:0] xMin;
  logic [CW-1:0] xMax;
  logic [CW-1:0] yMin;
  logic [CW-1:0] yMax;
  logic          startPend;

  logic [NW-1:0] cntUpd;
  logic [CW-1:0] xMinUpd;
  logic [CW-1:0] xMaxUpd;
  logic [CW-1:0] yMinUpd;
  logic [CW-1:0] yMaxUpd;

  assign cntUpd  = (cnt == CNT_MAX) ? cnt : cnt + NW'(1);
  assign xMinUpd = (hS1 < xMin) ? hS1 : xMin;
  assign xMaxUpd = (hS1 > xMax) ? hS1 : xMax;
  assign yMinUpd = (vS1 < yMin) ? vS1 : yMin;
  assign yMaxUpd = (vS1 > yMax) ? vS1 : yMax;

  // Box center from a 14-bit sum so that coordinates near 8191 do not wrap.
  logic [CW:0] xSum;
  logic [CW:0] ySum;

  assign xSum = {1'b0, xMin} + {1'b0, xMax};
  assign ySum = {1'b0, yMin} + {1'b0, yMax};

  // Result of the frame in the accumulators; an empty frame reports zeros.
  logic cntZero;
  assign cntZero = (cnt == '0);

  // ---------------------------------------------------------------------------
  // Frame FSM, accumulators and registered result outputs.
  // ---------------------------------------------------------------------------
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      state     <= IDLE;
      startPend <= 1'b0;
      cnt       <= '0;
      xMin      <= COORD_MAX;
      xMax      <= '0;
      yMin      <= COORD_MAX;
      yMax      <= '0;
      oX_MIN    <= '0;
      oX_MAX    <= '0;
      oY_MIN    <= '0;
      oY_MAX    <= '0;
      oX_C      <= '0;
      oY_C      <= '0;
      oCOUNT    <= '0;
      oFOUND    <= 1'b0;
      oRES_VAL  <= 1'b0;
      oBUSY     <= 1'b0;
    end else begin
      oRES_VAL <= 1'b0;

      case (state)
        IDLE: begin
          if (fvalRise) begin
            cnt   <= '0;
            xMin  <= COORD_MAX;
            xMax  <= '0;
            yMin  <= COORD_MAX;
            yMax  <= '0;
            oBUSY <= 1'b1;
            state <= ACCUM;
          end
        end

        ACCUM: begin
          if (darkS1) begin
            cnt  <= cntUpd;
            xMin <= xMinUpd;
            xMax <= xMaxUpd;
            yMin <= yMinUpd;
            yMax <= yMaxUpd;
          end
          if (fvalFall) state <= FLUSH;
        end

        // Absorb whatever pixel was in stage 1 when the frame ended.
        FLUSH: begin
          if (darkS1) begin
            cnt  <= cntUpd;
            xMin <= xMinUpd;
            xMax <= xMaxUpd;
            yMin <= yMinUpd;
            yMax <= yMaxUpd;
          end
          if (fvalRise) startPend <= 1'b1;
          state <= DONE;
        end

        DONE: begin
          oRES_VAL <= 1'b1;
          oCOUNT   <= cnt;
          oFOUND   <= !cntZero && (cnt >= MIN_COUNT);
          if (cntZero) begin
            oX_MIN <= '0;
            oX_MAX <= '0;
            oY_MIN <= '0;
            oY_MAX <= '0;
            oX_C   <= '0;
            oY_C   <= '0;
          end else begin
            oX_MIN <= xMin;
            oX_MAX <= xMax;
            oY_MIN <= yMin;
            oY_MAX <= yMax;
            oX_C   <= CW'(xSum >> 1);
            oY_C   <= CW'(ySum >> 1);
          end

          // A frame that started during FLUSH/DONE begins accumulating now;
          // pixels it delivered before this point are dropped by the clear.
          if (startPend || fvalRise) begin
            startPend <= 1'b0;
            cnt       <= '0;
            xMin      <= COORD_MAX;
            xMax      <= '0;
            yMin      <= COORD_MAX;
            yMax      <= '0;
            oBUSY     <= 1'b1;
            state     <= ACCUM;
          end else begin
            oBUSY <= 1'b0;
            state <= IDLE;
          end
        end

        default: begin
          oBUSY <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pupil_locator.sv
// Testbench for pupil_locator: frames of pixels are generated (fixed patterns
// plus randomized ones), a frame-level reference computes the expected count,
// bounding box, center, found flag and strobe cycle, and a monitor compares
// every result strobe against the queue of expectations.
module tb_pupil_locator;

  localparam int MIN_CNT = 64;
  localparam int DARK_TH = 128;

  logic        iCLK = 1'b0;
  logic        iRST = 1'b0;
  logic        iFVAL = 1'b0;
  logic        iDVAL = 1'b0;
  logic [12:0] iH_Cont = '0;
  logic [12:0] iV_Cont = '0;
  logic [9:0]  iRed = '0;
  logic [9:0]  iGreen = '0;
  logic [9:0]  iBlue = '0;
  logic [12:0] oX_MIN, oX_MAX, oY_MIN, oY_MAX, oX_C, oY_C;
  logic [23:0] oCOUNT;
  logic        oFOUND, oRES_VAL, oBUSY;

  pupil_locator dut (
    .iCLK(iCLK), .iRST(iRST), .iFVAL(iFVAL), .iDVAL(iDVAL),
    .iH_Cont(iH_Cont), .iV_Cont(iV_Cont),
    .iRed(iRed), .iGreen(iGreen), .iBlue(iBlue),
    .oX_MIN(oX_MIN), .oX_MAX(oX_MAX), .oY_MIN(oY_MIN), .oY_MAX(oY_MAX),
    .oX_C(oX_C), .oY_C(oY_C), .oCOUNT(oCOUNT), .oFOUND(oFOUND),
    .oRES_VAL(oRES_VAL), .oBUSY(oBUSY)
  );

  always #5 iCLK = ~iCLK;

  int unsigned cyc = 0;
  always @(posedge iCLK) cyc <= cyc + 1;

  typedef struct {
    int xmn, xmx, ymn, ymx, xc, yc, cnt, found;
    int unsigned due;
  } exp_t;

  exp_t expQ[$];
  exp_t monE;
  int   tests = 0;
  int   fails = 0;

  // Pattern controls for run_frame.
  int bx0, bx1, by0, by1;   // dark block (kind 1)
  int sx, sy, sval;         // single pixel of gray level sval (kind 2)
  int nDark;                // first nDark pixels dark (kind 3)

  task automatic chk(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  // Monitor: every result strobe must match the oldest outstanding frame.
  always @(negedge iCLK) begin
    if (iRST && oRES_VAL) begin
      if (expQ.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_result: strobe at cycle %0d, expected none", cyc);
      end else begin
        monE = expQ.pop_front();
        chk("latency",  int'(cyc),    int'(monE.due));
        chk("count",    int'(oCOUNT), monE.cnt);
        chk("x_min",    int'(oX_MIN), monE.xmn);
        chk("x_max",    int'(oX_MAX), monE.xmx);
        chk("y_min",    int'(oY_MIN), monE.ymn);
        chk("y_max",    int'(oY_MAX), monE.ymx);
        chk("x_center", int'(oX_C),   monE.xc);
        chk("y_center", int'(oY_C),   monE.yc);
        chk("found",    int'(oFOUND), monE.found);
      end
    end
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_count"}, int'(oCOUNT), 0);
    chk({tag, "_xmin"},  int'(oX_MIN), 0);
    chk({tag, "_ymin"},  int'(oY_MIN), 0);
    chk({tag, "_xmax"},  int'(oX_MAX), 0);
    chk({tag, "_xc"},    int'(oX_C),   0);
    chk({tag, "_found"}, int'(oFOUND), 0);
    chk({tag, "_resval"}, int'(oRES_VAL), 0);
    chk({tag, "_busy"},  int'(oBUSY),  0);
  endtask

  // Pixel stream that must be ignored: valid and dark but outside any frame.
  task automatic drive_garbage();
    iDVAL   = 1'b1;
    iRed    = 10'd0;
    iGreen  = 10'd0;
    iBlue   = 10'd0;
    iH_Cont = 13'($urandom_range(0, 8191));
    iV_Cont = 13'($urandom_range(0, 8191));
  endtask

  // One frame: 2 blanking cycles, raster of w x h pixels with a blank cycle
  // between rows, iFVAL dropped right after the last pixel, then gapAfter
  // cycles with iFVAL low. abortRow >= 0 pulses reset at that row.
  task automatic run_frame(input int x0, input int w, input int y0, input int h,
                           input int kind, input int gapAfter, input int abortRow);
    int  cnt, xmn, xmx, ymn, ymx, idx, r, g, b, gr, mode;
    bit  dv, aborted;
    exp_t e;
    cnt = 0; xmn = 1 << 30; xmx = -1; ymn = 1 << 30; ymx = -1;
    idx = 0; aborted = 0;

    iFVAL = 1'b1;
    iDVAL = 1'b0;
    tick();
    tick();
    if (abortRow < 0) chk("busy_in_frame", int'(oBUSY), 1);

    for (int y = y0; y < y0 + h; y++) begin
      if (!aborted && (y - y0) == abortRow) begin
        iRST  = 1'b0;
        iDVAL = 1'b0;
        tick();
        chk_all_zero("reset_mid_frame");
        tick();
        iRST = 1'b1;
        tick();
        tick();
        chk("busy_after_release", int'(oBUSY), 0);
        aborted = 1;
      end
      for (int x = x0; x < x0 + w; x++) begin
        case (kind)
          0: begin
            mode = $urandom_range(0, 2);
            if (mode == 0) begin
              r = $urandom_range(0, 1023); g = $urandom_range(0, 1023); b = $urandom_range(0, 1023);
            end else if (mode == 1) begin
              r = $urandom_range(110, 150); g = $urandom_range(110, 150); b = $urandom_range(110, 150);
            end else begin
              r = $urandom_range(0, 60); g = $urandom_range(0, 60); b = $urandom_range(0, 60);
            end
          end
          1: begin
            r = (x >= bx0 && x <= bx1 && y >= by0 && y <= by1) ? 20 : 900;
            g = r; b = r;
          end
          2: begin
            r = (x == sx && y == sy) ? sval : 900;
            g = r; b = r;
          end
          default: begin
            r = (idx < nDark) ? 20 : 900;
            g = r; b = r;
          end
        endcase
        dv = (kind == 0) ? ($urandom_range(0, 3) != 0) : 1'b1;
        iDVAL   = dv;
        iH_Cont = 13'(x);
        iV_Cont = 13'(y);
        iRed    = 10'(r);
        iGreen  = 10'(g);
        iBlue   = 10'(b);
        gr = (r + 2 * g + b) / 4;
        if (dv && !aborted && gr < DARK_TH) begin
          cnt++;
          if (x < xmn) xmn = x;
          if (x > xmx) xmx = x;
          if (y < ymn) ymn = y;
          if (y > ymx) ymx = y;
        end
        idx++;
        tick();
      end
      if (y != y0 + h - 1) begin
        iDVAL = 1'b0;
        tick();
      end
    end

    iFVAL = 1'b0;
    drive_garbage();
    if (!aborted) begin
      e.cnt   = cnt;
      e.found = (cnt >= MIN_CNT) ? 1 : 0;
      if (cnt == 0) begin
        e.xmn = 0; e.xmx = 0; e.ymn = 0; e.ymx = 0; e.xc = 0; e.yc = 0;
      end else begin
        e.xmn = xmn; e.xmx = xmx; e.ymn = ymn; e.ymx = ymx;
        e.xc = (xmn + xmx) / 2;
        e.yc = (ymn + ymx) / 2;
      end
      e.due = cyc + 3;
      expQ.push_back(e);
    end
    for (int i = 0; i < gapAfter; i++) begin
      tick();
      drive_garbage();
    end
    iDVAL = 1'b0;
  endtask

  initial begin
    // Reset state
    iRST = 1'b0;
    tick();
    tick();
    chk_all_zero("reset");
    iRST = 1'b1;
    tick();

    // Dark block 300..339 x 200..229 inside a cropped frame around it
    bx0 = 300; bx1 = 339; by0 = 200; by1 = 229;
    run_frame(290, 60, 195, 40, 1, 4, -1);

    // No dark pixels at all
    nDark = 0;
    run_frame(0, 16, 0, 4, 3, 4, -1);

    // Threshold edge: gray 127 counted, gray 128 not
    sx = 5; sy = 7; sval = 127;
    run_frame(0, 10, 5, 4, 2, 3, -1);
    sval = 128;
    run_frame(0, 10, 5, 4, 2, 3, -1);

    // Only dark pixel is the last one before iFVAL drops
    sx = 107; sy = 52; sval = 20;
    run_frame(100, 8, 50, 3, 2, 3, -1);

    // Found threshold at 63 / 64 dark pixels
    nDark = 63;
    run_frame(20, 10, 30, 8, 3, 3, -1);
    nDark = 64;
    run_frame(20, 10, 30, 8, 3, 3, -1);

    // Back-to-back frames with a single low cycle between them
    bx0 = 3; bx1 = 6; by0 = 2; by1 = 3;
    run_frame(0, 12, 0, 6, 1, 1, -1);
    bx0 = 9; bx1 = 10; by0 = 4; by1 = 5;
    run_frame(0, 12, 0, 6, 1, 1, -1);
    run_frame(500, 9, 700, 4, 0, 2, -1);

    // Coordinate extremes
    run_frame(8180, 12, 8186, 6, 0, 3, -1);
    nDark = 100000;
    run_frame(0, 6, 0, 3, 3, 3, -1);
    run_frame(8184, 8, 8188, 4, 3, 3, -1);

    // Reset mid-frame with iFVAL still high at release, then a normal frame
    nDark = 100000;
    run_frame(40, 12, 96, 8, 3, 3, 4);
    sx = 11; sy = 22; sval = 0;
    run_frame(8, 6, 20, 4, 2, 3, -1);

    // Randomized frames
    for (int k = 0; k < 20; k++) begin
      int w, h;
      w = $urandom_range(3, 24);
      h = $urandom_range(2, 10);
      run_frame($urandom_range(0, 8192 - w), w, $urandom_range(0, 8192 - h), h,
                0, $urandom_range(1, 4), -1);
    end

    repeat (10) tick();
    chk("all_results_seen", expQ.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pupil_locator.md
Name: pupil_locator

Overview:
- Consumer end of the masked RGB pixel stream. Sits downstream of the horizontal-window masking stage in the pupil-search pipeline.
- Classifies each valid pixel as dark or not. Over one frame, accumulates the bounding box and count of dark pixels.
- At frame end, publishes the box, its center and a found flag, qualified by a one-cycle result strobe.
- The result feeds the pupil overlay and coordinate-readout logic.

Parameters:
- THRESH, 10'd128: dark threshold; a pixel is dark when gray < THRESH (strict).
- MIN_COUNT, 24'd64: minimum dark-pixel count for oFOUND=1.

Ports:
- iCLK  input  1  pixel clock.
- iRST  input  1  reset, asynchronous, active-low.
- iFVAL  input  1  frame valid from capture; high for the whole frame.
- iDVAL  input  1  pixel valid.
- iH_Cont  input  13  pixel column.
- iV_Cont  input  13  pixel row.
- iRed, iGreen, iBlue  input  10 each  pixel color; masked pixels arrive as 0.
- oX_MIN, oX_MAX, oY_MIN, oY_MAX  output  13 each  dark bounding box of the last completed frame.
- oX_C, oY_C  output  13 each  box center.
- oCOUNT  output  24  dark-pixel count of the last frame.
- oFOUND  output  1  oCOUNT >= MIN_COUNT.
- oRES_VAL  output  1  one-cycle strobe when the outputs update.
- oBUSY  output  1  high while a frame is being accumulated or flushed.

Behaviour:
- Reset (iRST low, async):
  - All outputs 0, including oX_MIN and oY_MIN.
  - State IDLE; accumulators cleared.
  - The internal iFVAL delay register resets to 1, so a frame already in progress at reset release is ignored; the first rising edge seen is the next genuine one.
- Edge detect: fval_d <= iFVAL each cycle.
  - rise = iFVAL & ~fval_d; fall = ~iFVAL & fval_d.
- Stage 1 (registered, 1 cycle):
  - gray = (R + 2*G + B) >> 2. Sum is 12 bits, no overflow; result is 10 bits.
  - dark_s1 = iDVAL & iFVAL & (gray < THRESH).
  - H and V coordinates are registered alongside.
- Stage 2, in ACCUM when dark_s1:
  - cnt increments, saturating at 24'hFFFFFF.
  - xmin <= min(xmin,H); xmax <= max(xmax,H); likewise for y.
  - Accumulator clear values: xmin=ymin=13'h1FFF, xmax=ymax=0, cnt=0.
- States:
  - IDLE: on rise, clear accumulators and go to ACCUM; oBUSY=1 from the next cycle.
  - ACCUM: accumulate. On fall, go to FLUSH. A pixel in stage 1 at that moment is still accumulated in FLUSH.
  - FLUSH (1 cycle): absorb the last stage-1 pixel, then go to DONE.
  - DONE (1 cycle):
    - Latch oX_MIN..oY_MAX and oCOUNT.
    - oX_C = (xmin+xmax)>>1 and oY_C = (ymin+ymax)>>1, using a 14-bit sum.
    - oFOUND = (cnt >= MIN_COUNT).
    - oRES_VAL=1 for this cycle only.
    - Next state is IDLE, or ACCUM with cleared accumulators if a start is pending.
- Zero dark pixels in a frame (cnt=0): box and center outputs are forced to 0, oFOUND=0, and oRES_VAL still pulses.
- Latency: oRES_VAL asserts exactly 3 cycles after the first cycle iFVAL is sampled low (fall, FLUSH, DONE).
- Rise during FLUSH or DONE:
  - A start-pending flag is set; the result of the finished frame is still emitted.
  - Pixels arriving before ACCUM is re-entered are dropped.
- iDVAL while iFVAL is low, or while in IDLE: ignored.
- Coordinate range: the full 13 bits (0..8191) are honored.
- Latched outputs hold until the next DONE.
- Reset mid-frame: the frame is aborted and no oRES_VAL is issued.

Test Plan:
- Dark block: 640x480 frame; pixels with H 300..339 and V 200..229 are R=G=B=20, all others 900. Expect after fall: oX_MIN=300, oX_MAX=339, oY_MIN=200, oY_MAX=229, oX_C=319, oY_C=214, oCOUNT=1200, oFOUND=1, and oRES_VAL a single pulse 3 cycles after fall.
- No dark pixels: all pixels 900. Expect oCOUNT=0, box and center outputs 0, oFOUND=0, oRES_VAL pulses.
- Threshold edge, one frame, MIN_COUNT=1:
  - Single pixel gray=127 (R=G=B=127) at (5,7): counted. Expect oCOUNT=1, oX_MIN=oX_MAX=5, oY_MIN=oY_MAX=7, oFOUND=1.
  - Single pixel gray=128 in another frame: not counted. Expect oCOUNT=0.
- Last-pixel flush: the only dark pixel arrives on the final iDVAL cycle, and iFVAL drops the next cycle. Expect oCOUNT=1, with its coordinates captured.
- Back-to-back frames: iFVAL low for only 1 cycle between frames with different dark boxes. Expect both results to emit in order, with the second unaffected by the first.
- Resets:
  - Reset mid-frame: pulse iRST low during row 100 of frame A. Expect all outputs 0, no oRES_VAL for frame A.
  - Reset with iFVAL high: if iFVAL is still high at release, expect no accumulation until the next rise.
